// File: rtl/urgent_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick : combinational masked priority encoder.
//
// Searches vec upward from index ptr, wrapping modulo N, and returns the first
// set bit as both a one-hot vector and a binary index. With ptr tied to zero
// this degenerates into a plain lowest-index-wins priority encoder.
//
// Ports
//   vec     in   N   candidate request vector
//   ptr     in   W   starting index of the search (must be < N)
//   onehot  out  N   one-hot pick, all-zero when vec is zero
//   idx     out  W   index of the pick, zero when vec is zero
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N = 8,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx
);

   int   j;
   logic found;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      j      = 0;
      for (int i = 0; i < N; i++) begin
         // ptr is always below N, so one subtraction is enough to wrap.
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!found && vec[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            idx       = W'(j);
         end
      end
   end

endmodule

// File: rtl/urgent_rr_arbiter.sv
// -----------------------------------------------------------------------------
// urgent_rr_arbiter : N-requester arbiter with a normal and an urgent class.
//
// Urgent candidates (ready & ready_urgent) always win over normal candidates
// (ready). The winner is registered as a one-hot grant, valid for one cycle;
// held requests are simply re-arbitrated every cycle.
//
// Build option: define ARB_ROUND_ROBIN_EN to search from a rotating pointer
// shared by both classes. Without it the lowest candidate index wins and no
// pointer exists. Flags and latency are the same in both builds.
//
// Ports
//   clk               in   1   rising-edge clock
//   rst               in   1   synchronous reset, active-high
//   ready             in   N   normal request vector
//   ready_urgent      in   N   urgent qualifier, only meaningful where ready=1
//   sel               out  N   registered one-hot grant, zero when none
//   sel_valid         out  1   registered, grant present (ready != 0)
//   sel_valid_urgent  out  1   registered, grant came from the urgent class
// -----------------------------------------------------------------------------
module urgent_rr_arbiter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] ready,
   input  logic [N-1:0] ready_urgent,
   output logic [N-1:0] sel,
   output logic         sel_valid,
   output logic         sel_valid_urgent
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0] u_vec;
   logic         u_any;
   logic [N-1:0] u_onehot;
   logic [N-1:0] r_onehot;
   logic [W-1:0] u_idx;
   logic [W-1:0] r_idx;
   logic [W-1:0] ptr_q;

   // Urgent bits without the matching ready bit are not requests at all.
   assign u_vec = ready & ready_urgent;
   assign u_any = |u_vec;

   rr_pick #(.N(N), .W(W)) u_pick_urgent (
      .vec    (u_vec),
      .ptr    (ptr_q),
      .onehot (u_onehot),
      .idx    (u_idx)
   );

   rr_pick #(.N(N), .W(W)) u_pick_normal (
      .vec    (ready),
      .ptr    (ptr_q),
      .onehot (r_onehot),
      .idx    (r_idx)
   );

`ifdef ARB_ROUND_ROBIN_EN
   logic [W-1:0] grant_idx;

   assign grant_idx = u_any ? u_idx : r_idx;

   // Pointer moves just past the winner, whichever class it came from.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (|ready) begin
         if (grant_idx == W'(N - 1)) ptr_q <= '0;
         else                        ptr_q <= grant_idx + 1'b1;
      end
   end
`else
   logic unused_idx;

   // Fixed priority: the search always starts at index 0.
   assign ptr_q      = '0;
   assign unused_idx = ^{u_idx, r_idx};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sel              <= '0;
         sel_valid        <= 1'b0;
         sel_valid_urgent <= 1'b0;
      end else begin
         sel              <= u_any ? u_onehot : r_onehot;
         sel_valid        <= |ready;
         sel_valid_urgent <= u_any;
      end
   end

endmodule

// File: tb/tb_urgent_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_urgent_rr_arbiter : self-checking bench for urgent_rr_arbiter (N = 8).
// Expected grants come from a behavioural model of the arbitration rules that
// tracks the search start position as a plain integer.
// -----------------------------------------------------------------------------
module tb_urgent_rr_arbiter;

   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic [N-1:0] ready;
   logic [N-1:0] ready_urgent;
   logic [N-1:0] sel;
   logic         sel_valid;
   logic         sel_valid_urgent;

   int n_tests = 0;
   int n_fail  = 0;

   // model state and scoreboard queues
   int           m_ptr = 0;
   logic [N-1:0] exp_q[$];
   logic         exp_v_q[$];
   logic         exp_vu_q[$];

   urgent_rr_arbiter #(.N(N)) dut (
      .clk              (clk),
      .rst              (rst),
      .ready            (ready),
      .ready_urgent     (ready_urgent),
      .sel              (sel),
      .sel_valid        (sel_valid),
      .sel_valid_urgent (sel_valid_urgent)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model(input logic r_in, input logic [N-1:0] r, input logic [N-1:0] u);
      logic [N-1:0] uu;
      logic [N-1:0] c;
      logic [N-1:0] g;
      int           start;
      int           k;
      uu = r & u;
      c  = (uu != 0) ? uu : r;
      g  = '0;
      if (r_in) begin
         m_ptr = 0;
         exp_q.push_back('0);
         exp_v_q.push_back(1'b0);
         exp_vu_q.push_back(1'b0);
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
         start = m_ptr;
`else
         start = 0;
`endif
         for (int i = 0; i < N; i++) begin
            k = (start + i) % N;
            if (g == 0 && c[k]) begin
               g     = '0;
               g[k]  = 1'b1;
               m_ptr = (k + 1) % N;
            end
         end
         exp_q.push_back(g);
         exp_v_q.push_back(r != 0);
         exp_vu_q.push_back(uu != 0);
      end
   endtask

   // Drive one cycle of inputs, update the model, sample after the edge.
   task automatic step(input logic r_in, input logic [N-1:0] r, input logic [N-1:0] u);
      @(negedge clk);
      rst          = r_in;
      ready        = r;
      ready_urgent = u;
      model(r_in, r, u);
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [N-1:0] e_sel;
      logic         e_v, e_vu;
      step(1'b1, '0, '0);
      step(1'b1, '0, '0);
      e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      n_tests++;
      if (sel !== '0 || sel_valid !== 1'b0 || sel_valid_urgent !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state got sel=%h v=%b vu=%b exp 00/0/0", sel, sel_valid, sel_valid_urgent);
      end
      step(1'b0, 8'h00, 8'h00);
      e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      n_tests++;
      if (sel !== e_sel || sel_valid !== e_v || sel_valid_urgent !== e_vu) begin
         n_fail++;
         $display("FAIL idle got sel=%h v=%b vu=%b exp %h/%b/%b", sel, sel_valid, sel_valid_urgent, e_sel, e_v, e_vu);
      end
   endtask

   task automatic test_urgent_walk();
      logic [N-1:0] e_sel;
      logic         e_v, e_vu;
      logic [N-1:0] pat;
      for (int i = 0; i < 3; i++) begin
         pat = '0;
         pat[i] = 1'b1;
         step(1'b0, pat, pat);
         e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
         n_tests++;
         if (sel !== e_sel || sel !== pat || sel_valid !== e_v || sel_valid_urgent !== e_vu) begin
            n_fail++;
            $display("FAIL urgent_walk[%0d] got sel=%h v=%b vu=%b exp %h/%b/%b", i, sel, sel_valid, sel_valid_urgent, e_sel, e_v, e_vu);
         end
      end
   endtask

   task automatic test_urgent_over_normal();
      logic [N-1:0] e_sel;
      logic         e_v, e_vu;
      step(1'b0, 8'h38, 8'h08);
      e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      n_tests++;
      if (sel !== e_sel || sel !== 8'h08 || sel_valid !== e_v || sel_valid_urgent !== 1'b1) begin
         n_fail++;
         $display("FAIL urgent_wins got sel=%h v=%b vu=%b exp %h/%b/%b", sel, sel_valid, sel_valid_urgent, e_sel, e_v, e_vu);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h38, 8'h00);
         e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
         n_tests++;
         if (sel !== e_sel || sel_valid !== e_v || sel_valid_urgent !== e_vu) begin
            n_fail++;
            $display("FAIL normal_hold[%0d] got sel=%h v=%b vu=%b exp %h/%b/%b", i, sel, sel_valid, sel_valid_urgent, e_sel, e_v, e_vu);
         end
      end
   endtask

   task automatic test_urgent_without_ready();
      logic [N-1:0] e_sel;
      logic         e_v, e_vu;
      step(1'b0, 8'h38, 8'h80);
      e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      n_tests++;
      if (sel !== e_sel || (sel & 8'h38) == 0 || sel_valid !== e_v || sel_valid_urgent !== 1'b0) begin
         n_fail++;
         $display("FAIL urgent_no_ready got sel=%h v=%b vu=%b exp %h/%b/%b", sel, sel_valid, sel_valid_urgent, e_sel, e_v, e_vu);
      end
   endtask

   task automatic test_wrap();
      logic [N-1:0] e_sel;
      logic         e_v, e_vu;
      // force a grant at bit 7 first, then hold 0x81
      step(1'b0, 8'h80, 8'h00);
      e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      n_tests++;
      if (sel !== e_sel || sel !== 8'h80 || sel_valid !== e_v || sel_valid_urgent !== e_vu) begin
         n_fail++;
         $display("FAIL wrap_setup got sel=%h exp %h", sel, e_sel);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h81, 8'h00);
         e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
         n_tests++;
         if (sel !== e_sel || sel_valid !== e_v || sel_valid_urgent !== e_vu) begin
            n_fail++;
            $display("FAIL wrap[%0d] got sel=%h v=%b vu=%b exp %h/%b/%b", i, sel, sel_valid, sel_valid_urgent, e_sel, e_v, e_vu);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic [N-1:0] e_sel;
      logic         e_v, e_vu;
      step(1'b0, 8'hFF, 8'h00);
      step(1'b0, 8'hFF, 8'h00);
      step(1'b1, 8'hFF, 8'hFF);
      for (int i = 0; i < 2; i++) begin
         e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      end
      e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      n_tests++;
      if (sel !== '0 || sel_valid !== 1'b0 || sel_valid_urgent !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset got sel=%h v=%b vu=%b exp 00/0/0", sel, sel_valid, sel_valid_urgent);
      end
      step(1'b0, 8'hFF, 8'h00);
      e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
      n_tests++;
      if (sel !== e_sel || sel !== 8'h01 || sel_valid !== e_v || sel_valid_urgent !== e_vu) begin
         n_fail++;
         $display("FAIL post_reset_grant got sel=%h v=%b vu=%b exp %h/%b/%b", sel, sel_valid, sel_valid_urgent, e_sel, e_v, e_vu);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] e_sel;
      logic         e_v, e_vu;
      logic [N-1:0] r, u;
      int           errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       r = '0;
            1:       r = N'(1 << $urandom_range(0, N - 1));
            default: r = N'($urandom);
         endcase
         u = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
         step(1'b0, r, u);
         e_sel = exp_q.pop_front(); e_v = exp_v_q.pop_front(); e_vu = exp_vu_q.pop_front();
         n_tests++;
         if (sel !== e_sel || sel_valid !== e_v || sel_valid_urgent !== e_vu) begin
            n_fail++;
            errs++;
            if (errs <= 10)
               $display("FAIL random[%0d] r=%h u=%h got sel=%h v=%b vu=%b exp %h/%b/%b", i, r, u, sel, sel_valid, sel_valid_urgent, e_sel, e_v, e_vu);
         end
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst          = 1'b1;
      ready        = '0;
      ready_urgent = '0;
      test_reset();
      test_urgent_walk();
      test_urgent_over_normal();
      test_urgent_without_ready();
      test_wrap();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
